// File: rtl/peripheral_regbank_pkg.sv
// peripheral_regbank_pkg: bus widths and access-size / response-code encodings
package peripheral_regbank_pkg;
  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int MEM_COUNT_W = 3;
  localparam int MEM_CODE_W = 3;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 3'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 3'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 3'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 3'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID = 3'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ = 3'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE = 3'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED = 3'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 3'd4;
endpackage

// File: rtl/peripheral_regbank_lane_align.sv
// periph_lane_align: byte-enable mask, write-data placement and read-lane extraction
module periph_lane_align
  import peripheral_regbank_pkg::*;
(
  input  logic [MEM_COUNT_W-1:0] count,
  input  logic [1:0]             lane,
  input  logic [WORD_W-1:0]      wr_data,
  input  logic [WORD_W-1:0]      rd_word,
  output logic [WORD_W-1:0]      be_mask,
  output logic [WORD_W-1:0]      wr_shift,
  output logic [WORD_W-1:0]      rd_lane
);
  logic [4:0] sh;
  // shift amount from lane, then mask/shift data into and out of that lane
  always_comb begin
    sh = count == MEM_COUNT_BYTE ? {lane, 3'b0} : count == MEM_COUNT_HALF ? {lane[1], 4'b0} : 5'd0;
    be_mask = count == MEM_COUNT_BYTE ? WORD_W'(8'hFF) << sh :
              count == MEM_COUNT_HALF ? WORD_W'(16'hFFFF) << sh :
              count == MEM_COUNT_WORD ? '1 : '0;
    wr_shift = wr_data << sh;
    rd_lane = (rd_word >> sh) & (be_mask >> sh);
  end
endmodule

// File: rtl/peripheral_regbank.sv
// peripheral_regbank: memory-mapped register bank with RO/W1C masks and hardware sticky set
module peripheral_regbank
  import peripheral_regbank_pkg::*;
#(
  parameter logic [ADDR_W-1:0]           ADDR_START = '0,
  parameter int                          REG_COUNT  = 4,
  parameter logic [WORD_W*REG_COUNT-1:0] RESET_VAL  = '0,
  parameter logic [WORD_W*REG_COUNT-1:0] WR_MASK    = '1,
  parameter logic [WORD_W*REG_COUNT-1:0] W1C_MASK   = '0
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [ADDR_W-1:0]             i_req_addr,
  input  logic [WORD_W-1:0]             i_req_wr_data,
  input  logic                          i_req_wr_en,
  input  logic [MEM_COUNT_W-1:0]        i_req_count,
  input  logic [WORD_W*REG_COUNT-1:0]   i_hw_set,
  output logic [WORD_W-1:0]             o_res_rd_data,
  output logic [MEM_CODE_W-1:0]         o_res_code,
  output logic                          o_res_valid,
  output logic [REG_COUNT-1:0]          o_wr_strobe,
  output logic [WORD_W*REG_COUNT-1:0]   o_exposed_mem
);
  localparam int IDX_W = REG_COUNT > 1 ? $clog2(REG_COUNT) : 1;
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * REG_COUNT);
  logic [WORD_W-1:0] regs [REG_COUNT];
  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic misaligned, oob, size_ok, wr_go, rd_go;
  logic [WORD_W-1:0] rd_word, be_mask, wr_shift, rd_lane, eff, w1c, merged;
  logic [REG_COUNT-1:0] wr_sel;
  logic [MEM_CODE_W-1:0] code_n;

  periph_lane_align u_lane (
    .count    (i_req_count),
    .lane     (i_req_addr[1:0]),
    .wr_data  (i_req_wr_data),
    .rd_word  (rd_word),
    .be_mask  (be_mask),
    .wr_shift (wr_shift),
    .rd_lane  (rd_lane)
  );

  // decode the request and build the merged value for the addressed register
  always_comb begin
    off = i_req_addr - ADDR_START;
    idx = off[IDX_W+1:2];
    misaligned = (i_req_count == MEM_COUNT_HALF && i_req_addr[0]) ||
                 (i_req_count == MEM_COUNT_WORD && i_req_addr[1:0] != 2'b0);
    oob = i_req_addr < ADDR_START || off >= SPAN;
    size_ok = i_req_count inside {MEM_COUNT_BYTE, MEM_COUNT_HALF, MEM_COUNT_WORD};
    wr_go = size_ok && !misaligned && !oob && i_req_wr_en;
    rd_go = size_ok && !misaligned && !oob && !i_req_wr_en;
    rd_word = oob ? '0 : regs[idx];
    eff = be_mask & WR_MASK[idx*WORD_W +: WORD_W];
    w1c = W1C_MASK[idx*WORD_W +: WORD_W];
    merged = (rd_word & ~eff) | (eff & ~w1c & wr_shift) | (eff & w1c & rd_word & ~wr_shift);
    wr_sel = wr_go ? REG_COUNT'(1) << idx : '0;
    code_n = i_req_count == MEM_COUNT_NONE ? MEM_CODE_INVALID :
             misaligned ? MEM_CODE_MISALIGNED :
             oob ? MEM_CODE_OUT_OF_BOUNDS :
             !size_ok ? MEM_CODE_INVALID :
             i_req_wr_en ? MEM_CODE_WRITE : MEM_CODE_READ;
  end

  // register state and registered response; hardware set is ORed last so it wins
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      for (int j = 0; j < REG_COUNT; j++) regs[j] <= RESET_VAL[j*WORD_W +: WORD_W];
      o_res_valid <= 1'b0;
      o_res_code <= MEM_CODE_INVALID;
      o_res_rd_data <= '0;
      o_wr_strobe <= '0;
    end else begin
      for (int j = 0; j < REG_COUNT; j++)
        regs[j] <= (wr_sel[j] ? merged : regs[j]) | i_hw_set[j*WORD_W +: WORD_W];
      o_res_valid <= i_req_count != MEM_COUNT_NONE;
      o_res_code <= code_n;
      o_res_rd_data <= rd_go ? rd_lane : '0;
      o_wr_strobe <= wr_sel;
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_exp
    assign o_exposed_mem[g*WORD_W +: WORD_W] = regs[g];
  end
endmodule

// File: tb/tb_peripheral_regbank.sv
// tb_peripheral_regbank: directed self-checking bench for peripheral_regbank
module tb_peripheral_regbank;
  import peripheral_regbank_pkg::*;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [127:0] RV = {32'h000000FF, 32'h00000055, 32'hA5A50000, 32'h00000000};
  localparam logic [127:0] WM = {32'hFFFFFFFF, 32'hFFFFFF00, 32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam logic [127:0] CM = {32'h000000FF, 96'h0};
  localparam logic [2:0] NONE = 3'd0, BYTE = 3'd1, HALF = 3'd2, WORD = 3'd3;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wr_data = '0;
  logic i_req_wr_en = 1'b0;
  logic [2:0] i_req_count = 3'd0;
  logic [127:0] i_hw_set = '0;
  logic [31:0] o_res_rd_data;
  logic [2:0] o_res_code;
  logic o_res_valid;
  logic [3:0] o_wr_strobe;
  logic [127:0] o_exposed_mem;
  int checks = 0;
  int errors = 0;

  peripheral_regbank #(
    .ADDR_START (BASE),
    .REG_COUNT  (4),
    .RESET_VAL  (RV),
    .WR_MASK    (WM),
    .W1C_MASK   (CM)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .i_req_addr    (i_req_addr),
    .i_req_wr_data (i_req_wr_data),
    .i_req_wr_en   (i_req_wr_en),
    .i_req_count   (i_req_count),
    .i_hw_set      (i_hw_set),
    .o_res_rd_data (o_res_rd_data),
    .o_res_code    (o_res_code),
    .o_res_valid   (o_res_valid),
    .o_wr_strobe   (o_wr_strobe),
    .o_exposed_mem (o_exposed_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic rsp(input string tag, input logic v, input logic [2:0] code, input logic [31:0] rd);
    chk({tag, ".valid"}, 128'(o_res_valid), 128'(v));
    chk({tag, ".code"}, 128'(o_res_code), 128'(code));
    chk({tag, ".rd"}, 128'(o_res_rd_data), 128'(rd));
  endtask

  task automatic acc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] c);
    @(negedge clk);
    i_req_addr = a;
    i_req_wr_data = d;
    i_req_wr_en = w;
    i_req_count = c;
    @(posedge clk);
    #1;
    i_req_count = NONE;
    i_req_wr_en = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rg(input int j);
    return o_exposed_mem[j*32 +: 32];
  endfunction

  initial begin
    i_req_addr = BASE;
    i_req_wr_data = 32'hDEAD;
    i_req_wr_en = 1'b1;
    i_req_count = WORD;
    repeat (2) @(posedge clk);
    #1;
    rsp("rst", 1'b0, MEM_CODE_INVALID, 32'h0);
    chk("rst.strobe", 128'(o_wr_strobe), 128'h0);
    chk("rst.mem", o_exposed_mem, RV);
    aresetn = 1'b1;
    i_req_count = NONE;
    i_req_wr_en = 1'b0;
    acc(BASE + 4, 32'h0, 1'b0, WORD);
    rsp("rd_reg1", 1'b1, MEM_CODE_READ, 32'hA5A50000);
    chk("rd_reg1.strobe", 128'(o_wr_strobe), 128'h0);
    idle();
    rsp("idle", 1'b0, MEM_CODE_INVALID, 32'h0);
    acc(BASE, 32'h11223344, 1'b1, WORD);
    rsp("wr_word", 1'b1, MEM_CODE_WRITE, 32'h0);
    chk("wr_word.strobe", 128'(o_wr_strobe), 128'h1);
    chk("wr_word.reg0", 128'(rg(0)), 128'h11223344);
    idle();
    chk("wr_word.strobe_off", 128'(o_wr_strobe), 128'h0);
    acc(BASE + 2, 32'h000000EE, 1'b1, BYTE);
    rsp("wr_byte", 1'b1, MEM_CODE_WRITE, 32'h0);
    chk("wr_byte.strobe", 128'(o_wr_strobe), 128'h1);
    chk("wr_byte.reg0", 128'(rg(0)), 128'h11EE3344);
    idle();
    chk("wr_byte.strobe_off", 128'(o_wr_strobe), 128'h0);
    acc(BASE + 3, 32'h0, 1'b0, BYTE);
    rsp("rd_byte3", 1'b1, MEM_CODE_READ, 32'h11);
    acc(BASE + 1, 32'h0, 1'b0, BYTE);
    rsp("rd_byte1", 1'b1, MEM_CODE_READ, 32'h33);
    acc(BASE + 2, 32'h0, 1'b0, HALF);
    rsp("rd_half2", 1'b1, MEM_CODE_READ, 32'h11EE);
    acc(BASE, 32'hDEADBEEF, 1'b1, HALF);
    rsp("wr_half", 1'b1, MEM_CODE_WRITE, 32'h0);
    chk("wr_half.reg0", 128'(rg(0)), 128'h11EEBEEF);
    acc(BASE + 1, 32'h0, 1'b0, HALF);
    rsp("mis_rd", 1'b1, MEM_CODE_MISALIGNED, 32'h0);
    acc(BASE + 1, 32'hFFFFFFFF, 1'b1, HALF);
    rsp("mis_wr", 1'b1, MEM_CODE_MISALIGNED, 32'h0);
    chk("mis_wr.strobe", 128'(o_wr_strobe), 128'h0);
    chk("mis_wr.mem", o_exposed_mem, {32'hFF, 32'h55, 32'hA5A50000, 32'h11EEBEEF});
    acc(BASE + 2, 32'h0, 1'b0, WORD);
    rsp("mis_word", 1'b1, MEM_CODE_MISALIGNED, 32'h0);
    acc(BASE + 16, 32'h0, 1'b0, WORD);
    rsp("oob_hi", 1'b1, MEM_CODE_OUT_OF_BOUNDS, 32'h0);
    acc(BASE - 4, 32'hFFFFFFFF, 1'b1, WORD);
    rsp("oob_lo", 1'b1, MEM_CODE_OUT_OF_BOUNDS, 32'h0);
    chk("oob_lo.strobe", 128'(o_wr_strobe), 128'h0);
    chk("oob_lo.mem", o_exposed_mem, {32'hFF, 32'h55, 32'hA5A50000, 32'h11EEBEEF});
    acc(BASE + 18, 32'h0, 1'b0, WORD);
    rsp("mis_over_oob", 1'b1, MEM_CODE_MISALIGNED, 32'h0);
    acc(BASE, 32'hFFFFFFFF, 1'b1, 3'd5);
    rsp("bad_count", 1'b1, MEM_CODE_INVALID, 32'h0);
    chk("bad_count.mem", o_exposed_mem, {32'hFF, 32'h55, 32'hA5A50000, 32'h11EEBEEF});
    acc(BASE + 32, 32'h0, 1'b0, 3'd6);
    rsp("oob_over_bad", 1'b1, MEM_CODE_OUT_OF_BOUNDS, 32'h0);
    acc(BASE + 8, 32'hFFFFFFFF, 1'b1, WORD);
    chk("ro.strobe", 128'(o_wr_strobe), 128'h4);
    chk("ro.reg2", 128'(rg(2)), 128'hFFFFFF55);
    acc(BASE + 12, 32'h00000001, 1'b1, WORD);
    chk("w1c.strobe", 128'(o_wr_strobe), 128'h8);
    chk("w1c.reg3", 128'(rg(3)), 128'hFE);
    acc(BASE + 12, 32'hFFFF0000, 1'b1, WORD);
    chk("w1c_hold.reg3", 128'(rg(3)), 128'hFFFF00FE);
    i_hw_set[96] = 1'b1;
    idle();
    i_hw_set = '0;
    chk("hw_set.reg3", 128'(rg(3)), 128'hFFFF00FF);
    i_hw_set[96] = 1'b1;
    acc(BASE + 12, 32'h1, 1'b1, BYTE);
    i_hw_set = '0;
    rsp("collide", 1'b1, MEM_CODE_WRITE, 32'h0);
    chk("collide.reg3", 128'(rg(3)), 128'hFFFF00FF);
    acc(BASE + 12, 32'h1, 1'b1, BYTE);
    chk("w1c_byte.reg3", 128'(rg(3)), 128'hFFFF00FE);
    i_hw_set[31] = 1'b1;
    acc(BASE, 32'h0, 1'b1, WORD);
    i_hw_set = '0;
    chk("hw_vs_wr0.reg0", 128'(rg(0)), 128'h80000000);
    i_hw_set[65] = 1'b1;
    idle();
    i_hw_set = '0;
    chk("hw_ro.reg2", 128'(rg(2)), 128'hFFFFFF57);
    i_hw_set[32] = 1'b1;
    acc(BASE + 4, 32'h0, 1'b0, WORD);
    i_hw_set = '0;
    rsp("no_bypass", 1'b1, MEM_CODE_READ, 32'hA5A50000);
    chk("no_bypass.reg1", 128'(rg(1)), 128'hA5A50001);
    acc(BASE + 4, 32'h12345678, 1'b1, WORD);
    chk("pre_rst.strobe", 128'(o_wr_strobe), 128'h2);
    chk("pre_rst.reg1", 128'(rg(1)), 128'h12345678);
    aresetn = 1'b0;
    i_hw_set = '1;
    i_req_addr = BASE;
    i_req_wr_data = 32'hCAFE;
    i_req_wr_en = 1'b1;
    i_req_count = WORD;
    idle();
    rsp("mid_rst", 1'b0, MEM_CODE_INVALID, 32'h0);
    chk("mid_rst.strobe", 128'(o_wr_strobe), 128'h0);
    chk("mid_rst.mem", o_exposed_mem, RV);
    aresetn = 1'b1;
    i_hw_set = '0;
    i_req_count = NONE;
    i_req_wr_en = 1'b0;
    idle();
    rsp("post_rst", 1'b0, MEM_CODE_INVALID, 32'h0);
    chk("post_rst.mem", o_exposed_mem, RV);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
